// File: rtl/line_fit_check.sv
// Straight-line stream checker: recovers slope/intercept from y = m*x + c samples,
// locks after LOCK_CNT equal first differences and flags deviations. Optional error counter: LINE_FIT_ERRCNT_EN.
module line_fit_check #(
    parameter int W        = 32,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    input  logic [W-1:0]     y_in,
    input  logic             y_valid,
    output logic [W-1:0]     m_est,
    output logic [W-1:0]     c_est,
    output logic             locked,
    output logic             mismatch,
`ifdef LINE_FIT_ERRCNT_EN
    output logic [15:0]      err_cnt,
`endif
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {IDLE, FIRST, TRACK, LOCKED} state_t;

    state_t           state, state_n;
    logic [W-1:0]     y_prev, y_prev_n, d_ref, d_ref_n, m_n, c_n;
    logic [W-1:0]     d, lock_c;
    logic [MW-1:0]    match_cnt, match_n, match_inc;
    logic [CNT_W-1:0] cnt_n, cnt_inc;
    logic             locked_n, mismatch_n, accept, restart;
`ifdef LINE_FIT_ERRCNT_EN
    logic [15:0]      err_n;
`endif

    assign accept    = ce & y_valid & ~start;
    assign restart   = ce & start;
    assign d         = y_in - y_prev;
    assign cnt_inc   = sample_cnt + CNT_W'(1);
    assign match_inc = match_cnt + MW'(1);
    // The locking sample sits at x = cnt_inc, so c = y - m*x with m equal to this difference.
    assign lock_c    = y_in - d * W'(cnt_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            y_prev     <= '0;
            d_ref      <= '0;
            match_cnt  <= '0;
            m_est      <= '0;
            c_est      <= '0;
            sample_cnt <= '0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
`ifdef LINE_FIT_ERRCNT_EN
            err_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            y_prev     <= y_prev_n;
            d_ref      <= d_ref_n;
            match_cnt  <= match_n;
            m_est      <= m_n;
            c_est      <= c_n;
            sample_cnt <= cnt_n;
            locked     <= locked_n;
            mismatch   <= mismatch_n;
`ifdef LINE_FIT_ERRCNT_EN
            err_cnt    <= err_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        y_prev_n   = y_prev;
        d_ref_n    = d_ref;
        match_n    = match_cnt;
        m_n        = m_est;
        c_n        = c_est;
        cnt_n      = sample_cnt;
        locked_n   = locked;
        mismatch_n = 1'b0;

        if (restart) begin
            state_n  = IDLE;
            y_prev_n = '0;
            d_ref_n  = '0;
            match_n  = '0;
            m_n      = '0;
            c_n      = '0;
            cnt_n    = '0;
            locked_n = 1'b0;
        end else if (accept) begin
            cnt_n    = cnt_inc;
            y_prev_n = y_in;
            case (state)
                IDLE: state_n = FIRST;
                FIRST: begin
                    d_ref_n = d;
                    match_n = MW'(1);
                    if (LOCK_CNT == 1) begin
                        state_n  = LOCKED;
                        m_n      = d;
                        c_n      = lock_c;
                        locked_n = 1'b1;
                    end else begin
                        state_n = TRACK;
                    end
                end
                TRACK: begin
                    if (d == d_ref) begin
                        match_n = match_inc;
                        if (match_inc == MW'(LOCK_CNT)) begin
                            state_n  = LOCKED;
                            m_n      = d;
                            c_n      = lock_c;
                            locked_n = 1'b1;
                        end
                    end else begin
                        d_ref_n = d;
                        match_n = MW'(1);
                    end
                end
                LOCKED: begin
                    // Estimates are kept so the last good line stays visible after a break.
                    if (d != m_est) begin
                        state_n    = TRACK;
                        locked_n   = 1'b0;
                        mismatch_n = 1'b1;
                        d_ref_n    = d;
                        match_n    = MW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end

`ifdef LINE_FIT_ERRCNT_EN
        err_n = err_cnt;
        if (restart)
            err_n = '0;
        else if (mismatch_n && err_cnt != 16'hFFFF)
            err_n = err_cnt + 16'd1;
`endif
    end

endmodule

// File: tb/tb_line_fit_check.sv
// Directed-vector bench for line_fit_check: ramps, wrap, glitch/relock, ce gating, start and async reset.
module tb_line_fit_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        start;
    logic [31:0] y_in;
    logic        y_valid;
    logic [31:0] m_est;
    logic [31:0] c_est;
    logic        locked;
    logic        mismatch;
    logic [31:0] sample_cnt;
`ifdef LINE_FIT_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    line_fit_check dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .start      (start),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .m_est      (m_est),
        .c_est      (c_est),
        .locked     (locked),
        .mismatch   (mismatch),
`ifdef LINE_FIT_ERRCNT_EN
        .err_cnt    (err_cnt),
`endif
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic [31:0] y, input logic v, input logic c, input logic s);
        y_in    = y;
        y_valid = v;
        ce      = c;
        start   = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] y;
        rst = 1'b1; ce = 1'b0; start = 1'b0; y_in = '0; y_valid = 1'b0;
        #12;
        checkOutput("rst_m", m_est, 0);
        checkOutput("rst_c", c_est, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_mismatch", mismatch, 0);
        checkOutput("rst_cnt", sample_cnt, 0);
        rst = 1'b0;

        // Clean ramp m=3, c=5
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(32'(3 * i + 5), 1'b1, 1'b1, 1'b0);
            checkOutput("ramp_mismatch", mismatch, 0);
            checkOutput("ramp_locked", locked, (i == 5) ? 1 : 0);
        end
        checkOutput("ramp_m", m_est, 3);
        checkOutput("ramp_c", c_est, 5);
        checkOutput("ramp_cnt", sample_cnt, 5);

        // Wrap through zero
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("start_cnt", sample_cnt, 0);
        checkOutput("start_locked", locked, 0);
        y = 32'hFFFF_FFFE;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(y, 1'b1, 1'b1, 1'b0);
            y = y + 32'd3;
        end
        checkOutput("wrap_locked", locked, 1);
        checkOutput("wrap_m", m_est, 3);
        checkOutput("wrap_c", c_est, 32'hFFFF_FFFB);

        // Glitch while locked, then relock
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) applyStimulus(32'(2 * i), 1'b1, 1'b1, 1'b0);
        checkOutput("g_locked_pre", locked, 1);
        applyStimulus(32'd99, 1'b1, 1'b1, 1'b0);
        checkOutput("g_mismatch", mismatch, 1);
        checkOutput("g_locked", locked, 0);
        checkOutput("g_m_hold", m_est, 2);
        checkOutput("g_c_hold", c_est, 0);
        applyStimulus(32'd101, 1'b1, 1'b1, 1'b0);
        checkOutput("g_pulse_end", mismatch, 0);
        applyStimulus(32'd103, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'd105, 1'b1, 1'b1, 1'b0);
        checkOutput("g_not_yet", locked, 0);
        applyStimulus(32'd107, 1'b1, 1'b1, 1'b0);
        checkOutput("g_relock", locked, 1);
        checkOutput("g_relock_m", m_est, 2);
        checkOutput("g_relock_c", c_est, 85);
        checkOutput("g_relock_cnt", sample_cnt, 11);

        // ce gating with a stalled generator
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'd1, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'd2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'd3, 1'b1, 1'b0, 1'b0);
            checkOutput("ce_cnt_frozen", sample_cnt, 2);
            checkOutput("ce_mismatch", mismatch, 0);
        end
        for (int i = 3; i <= 5; i++) applyStimulus(32'(i), 1'b1, 1'b1, 1'b0);
        checkOutput("ce_locked", locked, 1);
        checkOutput("ce_m", m_est, 1);
        checkOutput("ce_c", c_est, 0);
        checkOutput("ce_cnt", sample_cnt, 5);

        // Break lock into TRACK, then async reset between edges
        applyStimulus(32'd50, 1'b1, 1'b1, 1'b0);
        checkOutput("ar_mismatch", mismatch, 1);
        checkOutput("ar_cnt_pre", sample_cnt, 6);
        rst = 1'b1;
        #2;
        checkOutput("ar_m", m_est, 0);
        checkOutput("ar_cnt", sample_cnt, 0);
        checkOutput("ar_mismatch_clr", mismatch, 0);
        checkOutput("ar_locked", locked, 0);
        #2;
        rst = 1'b0;

        // start with a same-cycle sample after lock
        for (int i = 1; i <= 5; i++) applyStimulus(32'(4 * i + 7), 1'b1, 1'b1, 1'b0);
        checkOutput("sv_locked_pre", locked, 1);
        checkOutput("sv_c_pre", c_est, 7);
        applyStimulus(32'd27, 1'b1, 1'b1, 1'b1);
        checkOutput("sv_locked", locked, 0);
        checkOutput("sv_cnt", sample_cnt, 0);
        checkOutput("sv_m", m_est, 0);
        checkOutput("sv_c", c_est, 0);
        applyStimulus(32'd10, 1'b1, 1'b1, 1'b0);
        checkOutput("sv_dropped", sample_cnt, 1);

`ifdef LINE_FIT_ERRCNT_EN
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b1);
        y = 32'd0;
        for (int i = 0; i < 5; i++) begin
            y = y + 32'd2;
            applyStimulus(y, 1'b1, 1'b1, 1'b0);
        end
        for (int g = 0; g < 3; g++) begin
            y = y + 32'd50;
            applyStimulus(y, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) begin
                y = y + 32'd2;
                applyStimulus(y, 1'b1, 1'b1, 1'b0);
            end
        end
        checkOutput("err_cnt", err_cnt, 3);
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("err_cnt_clr", err_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
